// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU execute stage: ALU control
//                codes, FSM state encoding and a shift-op classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // ALU control codes carried on in_op
  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SLL  = 5'd4;
  localparam logic [4:0] OP_SRL  = 5'd5;
  localparam logic [4:0] OP_SRA  = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;

  // Execute-stage control states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
//  Module      : alu_core
//  Description : Single-cycle combinational ALU for all non-shift operations.
//                Shift codes pass operand a through unchanged (the zero-amount
//                shift result); non-zero shifts are done serially by the parent.
//  Ports       : op     - ALU control code
//                a, b   - operands
//                result - operation result
//                lt     - signed a < b
//                ltu    - unsigned a < b
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            lt,
  output logic            ltu
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);
  assign ltu  = a < b;

  always_comb begin
    result = sum;  // undefined codes execute as ADD
    case (op)
      OP_AND:                 result = a & b;
      OP_OR:                  result = a | b;
      OP_ADD:                 result = sum;
      OP_SUB:                 result = diff;
      OP_XOR:                 result = a ^ b;
      OP_SLT:                 result = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU:                result = {{(XLEN-1){1'b0}}, ltu};
      OP_SLL, OP_SRL, OP_SRA: result = a;
      default:                result = sum;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
//  Module      : alu_exec
//  Description : ALU execute stage with valid/ready handshake on both sides,
//                a one-bit-per-cycle serial shifter and a registered output.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                in_valid / in_ready      - request handshake
//                in_op, in_a, in_b        - operation and operands
//                in_regwrite, in_rd       - sideband echoed to the output
//                out_valid / out_ready    - result handshake
//                out_result               - result
//                out_zero/out_lt/out_ltu  - result==0, signed/unsigned a<b
//                out_regwrite, out_rd     - captured sideband
//                busy                     - serial shift in progress
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_regwrite,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_lt,
  output logic            out_ltu,
  output logic            out_regwrite,
  output logic [4:0]      out_rd,
  output logic            busy
);

  state_t               state;
  logic [XLEN-1:0]      sh_reg;
  logic [SHAMT_W-1:0]   sh_cnt;
  logic [4:0]           sh_op;
  logic                 pend_lt;
  logic                 pend_ltu;
  logic                 pend_regwrite;
  logic [4:0]           pend_rd;

  logic [XLEN-1:0]      core_result;
  logic                 core_lt;
  logic                 core_ltu;
  logic [SHAMT_W-1:0]   amt;
  logic                 accept;
  logic                 start_shift;
  logic [XLEN-1:0]      sh_next;

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (core_result),
    .lt     (core_lt),
    .ltu    (core_ltu)
  );

  assign amt         = in_b[SHAMT_W-1:0];
  assign in_ready    = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = is_shift(in_op) && (amt != '0);
  assign busy        = (state == ST_SHIFT);

  // One-bit step of the serial shifter
  always_comb begin
    sh_next = {1'b0, sh_reg[XLEN-1:1]};
    case (sh_op)
      OP_SLL:  sh_next = {sh_reg[XLEN-2:0], 1'b0};
      OP_SRA:  sh_next = {sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
      default: sh_next = {1'b0, sh_reg[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sh_reg        <= '0;
      sh_cnt        <= '0;
      sh_op         <= '0;
      pend_lt       <= 1'b0;
      pend_ltu      <= 1'b0;
      pend_regwrite <= 1'b0;
      pend_rd       <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_lt        <= 1'b0;
      out_ltu       <= 1'b0;
      out_regwrite  <= 1'b0;
      out_rd        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Consumed result drops unless replaced by a new single-cycle op below
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (start_shift) begin
              state         <= ST_SHIFT;
              sh_reg        <= in_a;
              sh_cnt        <= amt;
              sh_op         <= in_op;
              pend_lt       <= core_lt;
              pend_ltu      <= core_ltu;
              pend_regwrite <= in_regwrite;
              pend_rd       <= in_rd;
            end else begin
              out_valid    <= 1'b1;
              out_result   <= core_result;
              out_zero     <= (core_result == '0);
              out_lt       <= core_lt;
              out_ltu      <= core_ltu;
              out_regwrite <= in_regwrite;
              out_rd       <= in_rd;
            end
          end
        end
        ST_SHIFT: begin
          // Output register is empty here: entry required it empty or draining
          sh_reg <= sh_next;
          sh_cnt <= sh_cnt - 1'b1;
          if (sh_cnt == SHAMT_W'(1)) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b1;
            out_result   <= sh_next;
            out_zero     <= (sh_next == '0);
            out_lt       <= pend_lt;
            out_ltu      <= pend_ltu;
            out_regwrite <= pend_regwrite;
            out_rd       <= pend_rd;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Self-checking bench for alu_exec: directed table, handshake
//                corner sequences and randomized ops against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_lt;
  logic        out_ltu;
  logic        out_regwrite;
  logic [4:0]  out_rd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  alu_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_regwrite  (in_regwrite),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_lt       (out_lt),
    .out_ltu      (out_ltu),
    .out_regwrite (out_regwrite),
    .out_rd       (out_rd),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        ltu;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural definition
  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a + b;
      5'd3:    return a - b;
      5'd4:    return a << sh;
      5'd5:    return a >> sh;
      5'd6:    return $unsigned($signed(a) >>> sh);
      5'd7:    return a ^ b;
      5'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10:   return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] b);
    if ((op == 5'd4 || op == 5'd5 || op == 5'd6) && (b % 32) != 0)
      return int'(b % 32) + 1;
    return 1;
  endfunction

  // Issue one op with out_ready high, wait for its result and check every field
  task automatic exec_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic rw, input logic [4:0] rd,
                            input logic [31:0] e_res, input logic e_z, input logic e_lt,
                            input logic e_ltu, input int e_lat);
    int guard;
    int lat;
    in_op = op; in_a = a; in_b = b; in_regwrite = rw; in_rd = rd;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick(); #1; guard++;
    end
    if (!in_ready) begin
      chk({tag, " accept_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;  // inputs must not matter after acceptance
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick(); lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " result"}, out_result, e_res);
    chk({tag, " zero"}, 32'(out_zero), 32'(e_z));
    chk({tag, " lt"}, 32'(out_lt), 32'(e_lt));
    chk({tag, " ltu"}, 32'(out_ltu), 32'(e_ltu));
    chk({tag, " regwrite"}, 32'(out_regwrite), 32'(rw));
    chk({tag, " rd"}, 32'(out_rd), 32'(rd));
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{5'd2,  32'd5,        32'd7,        32'd12,       1'b0, 1'b1, 1'b1, 1};
    tbl[1]  = '{5'd3,  32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b0, 1};
    tbl[2]  = '{5'd9,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{5'd10, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 1};
    tbl[4]  = '{5'd6,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b1, 1'b0, 5};
    tbl[5]  = '{5'd4,  32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b1, 1};
    tbl[7]  = '{5'd8,  32'd1,        32'd2,        32'd3,        1'b0, 1'b1, 1'b1, 1};
    tbl[8]  = '{5'd2,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 1};
    tbl[9]  = '{5'd5,  32'h80000000, 32'd31,       32'd1,        1'b0, 1'b1, 1'b0, 32};
    tbl[10] = '{5'd4,  32'd1,        32'h20,       32'd1,        1'b0, 1'b1, 1'b1, 1};
    tbl[11] = '{5'd7,  32'hAA,       32'hAA,       32'd0,        1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{5'd1,  32'h0F,       32'hF0,       32'hFF,       1'b0, 1'b1, 1'b1, 1};
    tbl[13] = '{5'd4,  32'hFFFFFFFF, 32'd31,       32'h80000000, 1'b0, 1'b1, 1'b0, 32};
    tbl[14] = '{5'd31, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0, 1};
    tbl[15] = '{5'd6,  32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 1'b0, 1'b0, 5};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_regwrite = 1'b0; in_rd = '0; out_ready = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst flags", {29'd0, out_zero, out_lt, out_ltu}, 32'd0);
    chk("rst sideband", {26'd0, out_regwrite, out_rd}, 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);

    // ---------------- directed table ----------------
    for (int i = 0; i < 16; i++) begin
      exec_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 1'(i % 2),
                 5'(i + 1), tbl[i].res, tbl[i].z, tbl[i].lt, tbl[i].ltu, tbl[i].lat);
    end

    // ---------------- busy / in_ready during serial shift ----------------
    in_op = 5'd6; in_a = 32'h80000000; in_b = 32'd4; in_regwrite = 1'b1; in_rd = 5'd17;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("sra accept ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b1; in_op = 5'd2;  // must be ignored while shifting
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sra busy c%0d", i), 32'(busy), 32'd1);
      chk($sformatf("sra in_ready c%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("sra out_valid c%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("sra done valid", 32'(out_valid), 32'd1);
    chk("sra done result", out_result, 32'hF8000000);
    chk("sra done rd", 32'(out_rd), 32'd17);
    chk("sra done busy", 32'(busy), 32'd0);

    // ---------------- backpressure and drain-cycle replacement ----------------
    tick();  // consume the SRA result
    chk("drain empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    in_op = 5'd2; in_a = 32'd10; in_b = 32'd20; in_rd = 5'd4; in_regwrite = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall valid c%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall result c%0d", i), out_result, 32'd30);
      chk($sformatf("stall rd c%0d", i), 32'(out_rd), 32'd4);
      chk($sformatf("stall in_ready c%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_op = 5'd3; in_a = 32'd50; in_b = 32'd8; in_rd = 5'd7; in_regwrite = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("drain in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b valid", 32'(out_valid), 32'd1);
    chk("b2b result", out_result, 32'd42);
    chk("b2b rd", 32'(out_rd), 32'd7);
    tick();
    chk("b2b no dup", 32'(out_valid), 32'd0);

    // ---------------- reset during serial shift ----------------
    in_op = 5'd5; in_a = 32'hFFFF0000; in_b = 32'd20; in_rd = 5'd9; in_regwrite = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort busy before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (out_valid) stale++;
      end
      chk("abort no stale result", 32'(stale), 32'd0);
    end

    // ---------------- randomized ops vs reference model ----------------
    for (int i = 0; i < 200; i++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [4:0]  ops [10];
      ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10};
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 9)];
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      r  = model_res(op, a, b);
      exec_check($sformatf("rnd%0d op%0d", i, op), op, a, b, 1'($urandom), 5'($urandom),
                 r, r == 32'd0, $signed(a) < $signed(b), a < b, model_lat(op, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width (log2 XLEN).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_op  input  5  ALU control code: AND=0 OR=1 ADD=2 SUB=3 SLL=4 SRL=5 SRA=6 XOR=7 SLT=9 SLTU=10.
REQ-008 SHALL have ports in_a, in_b  input  XLEN  operands; in_b[SHAMT_W-1:0] is the shift amount.
REQ-009 SHALL have ports in_regwrite (1) and in_rd (5)  input  sideband carried unchanged to the output.
REQ-010 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-012 SHALL have port out_result  output  XLEN  operation result.
REQ-013 SHALL have ports out_zero, out_lt, out_ltu  output  1 each  result==0, signed a<b, unsigned a<b.
REQ-014 SHALL have ports out_regwrite (1) and out_rd (5)  output  captured sideband.
REQ-015 SHALL have port busy  output  1  high while in state SHIFT.

Function
REQ-016 SHALL implement FSM states IDLE and SHIFT.
REQ-017 in_ready SHALL equal (state==IDLE) and (!out_valid or out_ready).
REQ-018 Non-shift op, or shift with amount 0, accepted in cycle N SHALL present out_valid=1 with the result in cycle N+1.
REQ-019 SLL/SRL/SRA with amount k>0 accepted in cycle N SHALL enter SHIFT, shift one bit per cycle, and present out_valid=1 in cycle N+k+1.
REQ-020 SRA SHALL replicate in_a[XLEN-1]; SRL/SLL SHALL fill with zeros.
REQ-021 ADD/SUB SHALL wrap modulo 2^XLEN; SLT/SLTU SHALL return 1 or 0 zero-extended.
REQ-022 Undefined in_op codes (8, 11-31) SHALL execute as ADD.
REQ-023 out_zero, out_lt and out_ltu SHALL be computed from the accepted operands for every op; out_zero SHALL reflect the final result.
REQ-024 All out_* fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 out_valid SHALL clear after a handshake unless a new request is accepted in the same cycle, in which case the new result replaces it per REQ-018/019.
REQ-026 in_valid SHALL be ignored in SHIFT; inputs are sampled only at acceptance.
REQ-027 On SHIFT completion the result SHALL load into the empty output register and the FSM SHALL return to IDLE.

Reset
REQ-028 rst SHALL force state=IDLE, out_valid=0, out_result=0, out_zero/out_lt/out_ltu=0, out_regwrite=0, out_rd=0 and the shift counter to 0.
REQ-029 rst asserted during SHIFT SHALL abort the operation with no output produced; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 Op-code constants and the FSM state encoding SHALL live in shared package alu_pkg, also used by the ALU control decoder.
REQ-031 Combinational non-shift operations SHALL be one sub-module, alu_core; the serial shifter and handshake logic SHALL stay in alu_exec.

Verification
REQ-032 ADD a=5 b=7 -> out_valid one cycle later, result 12, zero=0, regwrite/rd echoed.
REQ-033 SUB a=9 b=9 -> result 0, zero=1, lt=0; SLT a=0xFFFFFFFF b=1 -> 1; SLTU with the same operands -> 0.
REQ-034 SRA a=0x80000000 b=4 -> busy and in_ready=0 for 4 cycles, result 0xF8000000 in cycle N+5; SLL b=0 -> result=a in cycle N+1.
REQ-035 out_ready held low 3 cycles with out_valid=1 -> result stable, in_ready=0; back-to-back op accepted in the drain cycle -> new result in the next cycle, no loss or duplication.
REQ-036 rst pulsed during SRL b=20 -> out_valid=0 and in_ready=1 after reset; no stale result emitted.
